// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//
// Loadable down-counting timer. A start value is accepted over a valid/ready
// handshake, then decremented to zero once every DIV clock cycles. On reaching
// zero the timer spends one cycle in EXPIRE, during which `done` pulses.
//
// Parameters:
//   WIDTH  counter width in bits (>= 2)
//   DIV    clock cycles per decrement (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   load_valid  start request
//   load_value  start count, sampled on handshake
//   load_ready  timer can accept a load (IDLE)
//   pause       freeze the count while high (RUN only)
//   abort       cancel a running count
//   q           current count
//   busy        count in progress (RUN)
//   done        one-cycle expiry pulse (EXPIRE)
//
// Optional feature macro: DOWN_TIMER_RELOAD_EN
//   When defined, the last accepted load value is kept in a reload register
//   and EXPIRE restarts the count from it (periodic done) unless it is zero
//   or abort is high. When undefined, EXPIRE always returns to IDLE.
//
// All outputs decode from registered state only.
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    // Prescaler needs at least one bit even when DIV == 1.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q,   pre_d;
`ifdef DOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
`ifdef DOWN_TIMER_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE: begin
                // load_ready is 1 here, so load_valid alone is the handshake.
                if (load_valid) begin
`ifdef DOWN_TIMER_RELOAD_EN
                    reload_d = load_value;
`endif
                    if (load_value != '0) begin
                        count_d = load_value;
                        pre_d   = '0;
                        state_d = RUN;
                    end else begin
                        count_d = '0;
                        state_d = EXPIRE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    pre_d   = '0;
                    state_d = IDLE;
                end else if (!pause) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d   = '0;
                        count_d = count_q - WIDTH'(1);
                        // Leaving RUN at 1 -> 0 keeps q from ever wrapping.
                        if (count_q == WIDTH'(1)) begin
                            state_d = EXPIRE;
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
            end
            EXPIRE: begin
                count_d = '0;
                state_d = IDLE;
`ifdef DOWN_TIMER_RELOAD_EN
                // abort cannot cancel this cycle's done, only the restart.
                if (!abort && (reload_q != '0)) begin
                    count_d = reload_q;
                    pre_d   = '0;
                    state_d = RUN;
                end
`endif
            end
            default: begin
                count_d = '0;
                pre_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
`ifdef DOWN_TIMER_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
`ifdef DOWN_TIMER_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == EXPIRE);
    assign q          = count_q;

endmodule

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//
// Scoreboard bench for down_timer (WIDTH=4, DIV=3). The driver plans each
// transaction from the timer's rules (q = V - floor(elapsed/DIV), elapsed
// counting only unpaused cycles) and pushes per-cycle expected snapshots plus
// the expected done timestamp into queues. A separate monitor pops and
// compares on every falling edge, and matches each done pulse to a timestamp.
// -----------------------------------------------------------------------------
module tb_down_timer;

    localparam int WIDTH = 4;
    localparam int DIV   = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             load_ready;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    down_timer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .pause      (pause),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int q;
        int busy;
        int ready;
        int done;
    } snap_t;

    snap_t snap_q[$];
    int    done_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    bit    mon_done_en = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_snap(input int eq, input int eb, input int er, input int ed);
        snap_t s;
        s.q = eq; s.busy = eb; s.ready = er; s.done = ed;
        snap_q.push_back(s);
    endtask

    // Monitor: compares registered outputs away from the rising edge.
    always @(negedge clk) begin
        if (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            check("q",          int'(q),          s.q);
            check("busy",       int'(busy),       s.busy);
            check("load_ready", int'(load_ready), s.ready);
            check("done_level", int'(done),       s.done);
        end
        if (done && mon_done_en) begin
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else check("done_time", cyc, done_q.pop_front());
        end
    end

    // One load transaction. pmode: 0 random pauses, 1 none, 2 one 3-cycle
    // pause window mid-count. abort_q / rst_q: value of q at which abort /
    // reset is applied (-1 = never).
    task automatic run_txn(input int v, input int pmode, input int abort_q, input int rst_q);
        int  n, t, e, pc, guard, cur;
        bit  p, ab, ended;
        string how;
        t = v * DIV; e = 0; pc = 0; guard = 0; ended = 1'b0; how = "done";

        @(negedge clk);
        load_valid = 1'b1;
        load_value = WIDTH'(v);
        pause      = 1'($urandom_range(0, 1));
        abort      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n = cyc;
        if (t == 0) begin
            done_q.push_back(n);
            push_snap(0, 0, 0, 1);
        end else begin
            push_snap(v, 1, 0, 0);
        end

        while (e < t && guard < 8 * t + 20) begin
            guard++;
            @(negedge clk);
            cur = v - e / DIV;
            if (rst_q >= 0 && cur == rst_q && (e % DIV) == 0) begin
                #2 reset = 1'b0;
                #1;
                check("rst_q",     int'(q),          0);
                check("rst_busy",  int'(busy),       0);
                check("rst_ready", int'(load_ready), 1);
                check("rst_done",  int'(done),       0);
                load_valid = 1'b0; pause = 1'b0; abort = 1'b0;
                @(negedge clk);
                #1 reset = 1'b1;
                ended = 1'b1; how = "reset";
                break;
            end
            ab = (abort_q >= 0 && cur == abort_q && (e % DIV) == 0);
            case (pmode)
                0:       p = ($urandom_range(0, 3) == 0);
                2:       p = (e == t / 2) && (pc < 3);
                default: p = 1'b0;
            endcase
            if (p) pc++;
            load_valid = (pmode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            load_value = WIDTH'($urandom_range(0, 15));
            pause      = p;
            abort      = ab;
            @(posedge clk); #1;
            if (ab) begin
                push_snap(0, 0, 1, 0);
                ended = 1'b1; how = "abort";
                break;
            end
            if (!p) e++;
            if (e == t) begin
                done_q.push_back(cyc);
                push_snap(0, 0, 0, 1);
            end else begin
                push_snap(v - e / DIV, 1, 0, 0);
            end
        end
        if (!ended && e < t) begin
            check("txn_guard", e, t);
            ended = 1'b1; how = "timeout";
        end

        if (!ended) begin
            // EXPIRE cycle: loads ignored, abort cannot cancel the pulse.
            @(negedge clk);
            load_valid = 1'($urandom_range(0, 1));
            load_value = WIDTH'($urandom_range(1, 15));
            pause      = 1'($urandom_range(0, 1));
            abort      = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            push_snap(0, 0, 1, 0);
        end
        @(negedge clk);
        load_valid = 1'b0; pause = 1'b0; abort = 1'b0;
        $display("txn load=%0d accepted@%0d pauses=%0d end=%s", v, n, pc, how);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            pause = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            push_snap(0, 0, 1, 0);
        end
        @(negedge clk);
        pause = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_q",     int'(q),          0);
        check("reset_busy",  int'(busy),       0);
        check("reset_done",  int'(done),       0);
        check("reset_ready", int'(load_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

`ifndef DOWN_TIMER_RELOAD_EN
        run_txn(5, 1, -1, -1);   // plain count
        run_txn(2, 1, -1, -1);   // DIV=3 hold per value
        run_txn(4, 2, -1, -1);   // 3-cycle pause window
        run_txn(7, 1, 3, -1);    // abort at q=3
        run_txn(0, 1, -1, -1);   // zero load expires at once
        run_txn(9, 1, -1, 4);    // async reset at q=4
        run_txn(1, 1, -1, -1);
        run_txn(15, 0, -1, -1);  // max value
        for (int i = 0; i < 30; i++) begin
            int v, aq;
            v  = $urandom_range(0, 15);
            aq = (v > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, v) : -1;
            run_txn(v, 0, aq, -1);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
`else
        begin
            int n, t, pulses;
            mon_done_en = 1'b0;
            t = 3 * DIV;
            pulses = 0;
            @(negedge clk);
            load_valid = 1'b1; load_value = WIDTH'(3);
            @(posedge clk); #1;
            n = cyc;
            @(negedge clk);
            load_valid = 1'b0;
            for (int k = 0; k < 3 * (t + 1) + t; k++) begin
                int dt;
                bit exp_done;
                @(posedge clk); #1;
                dt = cyc - n;
                exp_done = (dt >= t) && (((dt - t) % (t + 1)) == 0);
                if (exp_done) pulses++;
                check("reload_done", int'(done), int'(exp_done));
                check("reload_ready", int'(load_ready), 0);
            end
            $display("reload load=3 accepted@%0d pulses=%0d", n, pulses);
            @(negedge clk);
            abort = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            abort = 1'b0;
            check("reload_abort_ready", int'(load_ready), 1);
            for (int k = 0; k < 2 * (t + 1); k++) begin
                @(posedge clk); #1;
                check("reload_stopped", int'(done), 0);
            end
        end
`endif

        repeat (3) @(negedge clk);
        #1;
        check("snap_drain", snap_q.size(), 0);
        check("done_drain", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer: the counterpart of the free-running up counter. It accepts a start value over a valid/ready handshake and decrements it to zero at a prescaled rate. At zero it emits a one-cycle `done` pulse. Used as the timeout/delay generator beside the up counter in the simulation test designs.

## Interface
- `WIDTH`, 4: counter width in bits; legal range ≥ 2.
- `DIV`, 1: clock cycles per decrement; legal range ≥ 1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  start request.
- `load_value`  in  WIDTH  start count, sampled on handshake.
- `load_ready`  out  1  timer can accept a load.
- `pause`  in  1  freeze the count while high.
- `abort`  in  1  cancel a running count.
- `q`  out  WIDTH  current count.
- `busy`  out  1  count in progress.
- `done`  out  1  one-cycle expiry pulse.

## Operation
- States: IDLE, RUN, EXPIRE. All outputs decode from registered state, `q` and the prescaler. No input-to-output combinational path.
- `load_ready` = (state == IDLE). `busy` = (state == RUN). `done` = (state == EXPIRE).
- Reset (`reset` = 0, asynchronous):
  - State goes to IDLE; `q`, prescaler and reload register clear to 0.
  - Outputs while in reset: `q` = 0, `busy` = 0, `done` = 0, `load_ready` = 1.
- IDLE:
  - Handshake = `load_valid` & `load_ready`.
  - On handshake with `load_value` ≠ 0: `q` ← `load_value`, prescaler ← 0, go to RUN.
  - On handshake with `load_value` = 0: `q` ← 0, go to EXPIRE.
  - `pause` and `abort` are ignored.
- RUN, priority order:
  1. `abort` = 1: `q` ← 0, go to IDLE, no `done`.
  2. `pause` = 1: `q` and prescaler hold.
  3. Otherwise the prescaler increments. When prescaler = DIV−1: prescaler ← 0 and `q` ← `q`−1. If that decrement takes `q` from 1 to 0, go to EXPIRE.
- EXPIRE:
  - `done` = 1 and `q` = 0 for exactly one cycle, then go to IDLE (see Configuration).
  - `abort` here does not suppress the current `done`; it forces IDLE.
- Arithmetic is unsigned, modulo 2^WIDTH. `q` never wraps below 0, because the timer leaves RUN at zero.
- `load_valid` outside IDLE is ignored and not queued.

## Timing
- Load accepted at edge N → `q` = V visible after edge N.
- With no pause, `q` reaches 0 at edge N + DIV·V; `done` is high during the following cycle.
- Each paused RUN cycle adds one cycle to that latency.
- Load of 0 at edge N → `done` is high in the cycle after edge N.
- Minimum back-to-back spacing, non-reload build: EXPIRE → IDLE → next load. The next load is accepted one cycle after the `done` cycle.
- Asserting `reset` mid-count returns the block to IDLE immediately; no `done` is produced.

## Configuration
- `DOWN_TIMER_RELOAD_EN` defined:
  - The last accepted `load_value` is stored in the reload register.
  - In EXPIRE, instead of going to IDLE: `q` ← reload value, prescaler ← 0, go to RUN. This gives a periodic `done` every DIV·V + 1 cycles.
  - If the reload value is 0, go to IDLE.
  - `abort` in RUN or EXPIRE returns to IDLE.
  - `load_ready` stays 0 until the timer is back in IDLE.
- `DOWN_TIMER_RELOAD_EN` not defined: no reload register; EXPIRE always goes to IDLE.

## Test plan
- Reset, then release; load 5 with DIV=1 → `q` steps 5,4,3,2,1,0; `done` is high for 1 cycle, 5 cycles after acceptance; `load_ready` returns 1 the cycle after.
- DIV=3, load 2 → `q` = 2 for 3 cycles, then 1 for 3 cycles; `done` 6 cycles after acceptance.
- Load 4, hold `pause` high for 3 cycles mid-count → `done` is delayed by exactly 3 cycles; `q` is constant while paused.
- Load 7, `abort` at `q` = 3 → `q` = 0 next cycle, IDLE, `done` never asserts. Load 0 → `done` the next cycle.
- Load 9, assert `reset` at `q` = 4 → `q` = 0 and `busy` = 0 immediately, `load_ready` = 1, no `done`. Also: `load_valid` held high during RUN → ignored; `q` is unaffected.
- With `DOWN_TIMER_RELOAD_EN`, load 3 → `done` pulses every 4 cycles repeatedly; `abort` → IDLE, pulses stop.
